// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param: sequential shift-add multiplier producing a 2*WIDTH product in WIDTH cycles.
// Unsigned or radix-2 Booth signed mode; rev 1.0.
`default_nettype none
`timescale 1ns/1ps

module seq_multiplier_param #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               n_reset,
  input  logic               START,
  input  logic               SIGNED_MODE,
  input  logic [WIDTH-1:0]   MCAND,
  input  logic [WIDTH-1:0]   MPLIER,
  output logic               READY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] AQ
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_m1_q, q_m1_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;
  logic             start_q, start_d;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
      mode_q  <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q_m1_q  <= q_m1_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q_m1_d  = q_m1_q;
    mode_d  = mode_q;
    count_d = count_q;
    done_d  = 1'b0;
    start_d = START;
    sum     = a_q;

    case (state_q)
      IDLE: begin
        if (START && !start_q) begin
          m_d     = SIGNED_MODE ? {MCAND[WIDTH-1], MCAND} : {1'b0, MCAND};
          a_d     = '0;
          q_d     = MPLIER;
          q_m1_d  = 1'b0;
          mode_d  = SIGNED_MODE;
          count_d = CW'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        if (mode_q) begin
          case ({q_q[0], q_m1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
          endcase
        end else if (q_q[0]) begin
          sum = a_q + m_q;
        end
        // The extra A bit holds the carry (unsigned) or sign (signed) across the shift
        a_d     = {mode_q & sum[WIDTH], sum[WIDTH:1]};
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        q_m1_d  = q_q[0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign READY = (state_q == IDLE);
  assign DONE  = done_q;
  assign AQ    = {a_q[WIDTH-1:0], q_q};

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier_param.sv
// tb_seq_multiplier_param: directed and random checks of seq_multiplier_param at WIDTH 4 and 8.
`timescale 1ns/1ps

module tb_seq_multiplier_param;

  logic        clock = 1'b0;
  logic        n_reset;
  logic        s4, sm4, r4, d4;
  logic [3:0]  mc4, mp4;
  logic [7:0]  aq4;
  logic        s8, sm8, r8, d8;
  logic [7:0]  mc8, mp8;
  logic [15:0] aq8;
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  seq_multiplier_param #(.WIDTH(4)) u4 (
    .clock(clock), .n_reset(n_reset), .START(s4), .SIGNED_MODE(sm4),
    .MCAND(mc4), .MPLIER(mp4), .READY(r4), .DONE(d4), .AQ(aq4)
  );

  seq_multiplier_param #(.WIDTH(8)) u8 (
    .clock(clock), .n_reset(n_reset), .START(s8), .SIGNED_MODE(sm8),
    .MCAND(mc8), .MPLIER(mp8), .READY(r8), .DONE(d8), .AQ(aq8)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the mathematical product of the operands as integers, kept to 2*w bits
  function automatic logic [15:0] ref_prod(input int w, input bit sg, input int a, input int b);
    longint x = longint'(a);
    longint y = longint'(b);
    longint mask = (longint'(1) << (2 * w)) - 1;
    if (sg && a >= (1 << (w - 1))) x = longint'(a) - (longint'(1) << w);
    if (sg && b >= (1 << (w - 1))) y = longint'(b) - (longint'(1) << w);
    return 16'((x * y) & mask);
  endfunction

  task automatic drive(input int w, input bit st, input bit sg, input int a, input int b);
    if (w == 4) begin
      s4 = st; sm4 = sg; mc4 = 4'(a); mp4 = 4'(b);
    end else begin
      s8 = st; sm8 = sg; mc8 = 8'(a); mp8 = 8'(b);
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 4) ? r4 : r8;
  endfunction

  function automatic logic dn(input int w);
    return (w == 4) ? d4 : d8;
  endfunction

  function automatic logic [15:0] prod(input int w);
    return (w == 4) ? {8'h00, aq4} : aq8;
  endfunction

  // One complete operation; operands and mode are scrambled after acceptance
  task automatic do_op(input int w, input bit sg, input int a, input int b, input string tag);
    logic [15:0] exp;
    exp = ref_prod(w, sg, a, b);
    drive(w, 1'b1, sg, a, b);
    tick();
    drive(w, 1'b0, !sg, int'($urandom), int'($urandom));
    check($sformatf("%s ready_low", tag), {15'b0, rdy(w)}, 16'd0);
    for (int i = 1; i < w; i++) begin
      tick();
      check($sformatf("%s busy%0d", tag, i), {14'b0, rdy(w), dn(w)}, 16'd0);
    end
    tick();
    check($sformatf("%s ready_done", tag), {14'b0, rdy(w), dn(w)}, 16'd3);
    check($sformatf("%s product", tag), prod(w), exp);
    tick();
    check($sformatf("%s done_drop", tag), {14'b0, rdy(w), dn(w)}, 16'd2);
    check($sformatf("%s product_hold", tag), prod(w), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int a, b;
    bit sg;

    n_reset = 1'b0;
    drive(4, 1'b0, 1'b0, 0, 0);
    drive(8, 1'b0, 1'b0, 0, 0);
    tick();
    tick();
    check("rst u4", {r4, d4, 6'b0, aq4}, 16'h8000);
    check("rst u8 ctl", {14'b0, r8, d8}, 16'd2);
    check("rst u8 aq", aq8, 16'h0000);
    n_reset = 1'b1;
    tick();

    do_op(4, 1'b0, 15, 15, "u4 15x15");
    check("u4 15x15 literal", {8'h00, aq4}, 16'h00E1);
    do_op(4, 1'b1, 13, 5, "s4 -3x5");
    check("s4 -3x5 literal", {8'h00, aq4}, 16'h00F1);
    do_op(4, 1'b1, 8, 8, "s4 -8x-8");
    check("s4 -8x-8 literal", {8'h00, aq4}, 16'h0040);

    // START held high 6 cycles, low 29, high 2: two operations only
    pulses = 0;
    drive(4, 1'b0, 1'b0, 6, 7);
    for (int i = 0; i < 50; i++) begin
      s4 = (i < 6) || (i >= 35 && i < 37);
      tick();
      if (d4) begin
        pulses++;
        check($sformatf("held product %0d", pulses), {8'h00, aq4}, 16'h002A);
      end
    end
    check("held pulse count", 16'(pulses), 16'd2);

    // Second edge two cycles into CALC is ignored
    drive(4, 1'b1, 1'b0, 9, 3);
    tick();
    drive(4, 1'b0, 1'b0, 9, 3);
    tick();
    drive(4, 1'b1, 1'b0, 5, 5);
    tick();
    drive(4, 1'b0, 1'b0, 5, 5);
    check("ignore busy k+2", {15'b0, r4}, 16'd0);
    tick();
    check("ignore busy k+3", {15'b0, r4}, 16'd0);
    tick();
    check("ignore ready_done", {14'b0, r4, d4}, 16'd3);
    check("ignore product", {8'h00, aq4}, 16'd27);
    tick();
    check("ignore no_retrigger", {14'b0, r4, d4}, 16'd2);

    // Reset in the middle of an operation discards it
    drive(4, 1'b1, 1'b0, 11, 13);
    tick();
    drive(4, 1'b0, 1'b0, 11, 13);
    tick();
    n_reset = 1'b0;
    tick();
    check("midrst state", {r4, d4, 6'b0, aq4}, 16'h8000);
    n_reset = 1'b1;
    tick();
    do_op(4, 1'b0, 11, 13, "after midrst");

    do_op(8, 1'b0, 255, 255, "u8 255x255");
    check("u8 255x255 literal", aq8, 16'hFE01);
    do_op(8, 1'b1, 128, 127, "s8 -128x127");
    check("s8 -128x127 literal", aq8, 16'hC080);
    do_op(8, 1'b1, 128, 128, "s8 -128x-128");

    for (int i = 0; i < 12; i++) begin
      sg = 1'($urandom);
      a  = int'($urandom_range(0, 15));
      b  = int'($urandom_range(0, 15));
      do_op(4, sg, a, b, $sformatf("rnd4 %0d m%0d %0dx%0d", i, sg, a, b));
      sg = 1'($urandom);
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      do_op(8, sg, a, b, $sformatf("rnd8 %0d m%0d %0dx%0d", i, sg, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
